// File: rtl/poly_synth_pkg.sv
// ============================================================================
// Module : poly_synth_pkg
// Brief  : Shared FSM states, waveform selectors, types and note increments
//          for the polyphonic synth engine.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package poly_synth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACC   = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    localparam logic [1:0] WAVE_ROM0   = 2'd0;
    localparam logic [1:0] WAVE_ROM1   = 2'd1;
    localparam logic [1:0] WAVE_SAW    = 2'd2;
    localparam logic [1:0] WAVE_SQUARE = 2'd3;

    typedef logic signed [15:0] sample_t;
    typedef logic        [23:0] phase_t;

    // A4 at the engine's frame rate; each octave doubles the increment
    localparam phase_t A4_INC = 24'h013491;
    localparam phase_t A5_INC = 24'h026922;
    localparam phase_t A6_INC = 24'h04D244;

endpackage

`default_nettype wire

// File: rtl/poly_voice_alloc.sv
// ============================================================================
// Module : poly_voice_alloc
// Brief  : Voice table (active flags, increments) with note-on match/free/steal
//          and note-off release; emits per-voice phase load strobes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module poly_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_valid,
    input  logic                  i_cmd_on,
    input  logic [PHASE_W-1:0]    i_cmd_inc,
    output logic [NUM_VOICES-1:0] o_active,
    output logic [PHASE_W-1:0]    o_inc [NUM_VOICES],
    output logic [NUM_VOICES-1:0] o_load
);

    localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [PHASE_W-1:0]    inc_q [NUM_VOICES];
    logic [PHASE_W-1:0]    inc_d [NUM_VOICES];
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_VOICES-1:0] match;
    logic [PTR_W-1:0]      free_idx;

    always_comb begin
        match    = '0;
        free_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            match[i] = active_q[i] && (inc_q[i] == i_cmd_inc);
        end
        // Downward scan leaves the lowest inactive index
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!active_q[i]) free_idx = PTR_W'(i);
        end
    end

    always_comb begin
        active_d = active_q;
        inc_d    = inc_q;
        ptr_d    = ptr_q;
        o_load   = '0;
        if (i_cmd_valid && (i_cmd_inc != '0)) begin
            if (!i_cmd_on) begin
                active_d = active_q & ~match;
            end else if (|match) begin
                o_load = match;
            end else if (&active_q) begin
                o_load[ptr_q] = 1'b1;
                inc_d[ptr_q]  = i_cmd_inc;
                ptr_d = (ptr_q == PTR_W'(NUM_VOICES - 1)) ? '0 : ptr_q + 1'b1;
            end else begin
                o_load[free_idx]   = 1'b1;
                inc_d[free_idx]    = i_cmd_inc;
                active_d[free_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= '0;
            ptr_q    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) inc_q[i] <= '0;
        end else begin
            active_q <= active_d;
            ptr_q    <= ptr_d;
            inc_q    <= inc_d;
        end
    end

    assign o_active = active_q;
    assign o_inc    = inc_q;

endmodule

`default_nettype wire

// File: rtl/poly_synth.sv
// ============================================================================
// Module : poly_synth
// Brief  : Time-multiplexed polyphonic wavetable/saw/square engine mixing
//          NUM_VOICES voices into one audio FIFO sample per frame.
//          POLY_SYNTH_SAT_EN: clamp the mixed sample instead of wrapping.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module poly_synth
    import poly_synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int SAMPLE_W   = 16,
    parameter int ADDR_W     = 12,
    parameter int ROM_LAT    = 2,
    parameter int MIX_SHIFT  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CMD_VALID,
    input  logic                  CMD_ON,
    input  logic [PHASE_W-1:0]    CMD_INC,
    input  logic [1:0]            WAVE_SEL,
    output logic [ADDR_W:0]       ROM_ADDR,
    input  logic [SAMPLE_W-1:0]   ROM_DATA,
    input  logic                  FIFO_FULL,
    output logic                  FIFO_WRITE,
    output logic [SAMPLE_W-1:0]   AUDIO_OUT,
    output logic [NUM_VOICES-1:0] ACTIVE
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int WCNT_W = $clog2(ROM_LAT + 1);
    localparam logic signed [SAMPLE_W-1:0] SQ_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

    state_t                   state_q, state_d;
    logic [VIDX_W-1:0]        v_q, v_d;
    logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
    logic [1:0]               wsel_q, wsel_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W:0]          rom_addr_q, rom_addr_d;
    logic [SAMPLE_W-1:0]      audio_q, audio_d;
    logic                     fifo_write_q, fifo_write_d;
    logic [PHASE_W-1:0]       phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]       phase_d [NUM_VOICES];

    logic [NUM_VOICES-1:0]    active;
    logic [NUM_VOICES-1:0]    load;
    logic [PHASE_W-1:0]       inc [NUM_VOICES];
    logic signed [SAMPLE_W-1:0] sample_v;
    logic [SAMPLE_W-1:0]      mix_out;
    logic                     phase_step;

    poly_voice_alloc #(
        .NUM_VOICES (NUM_VOICES),
        .PHASE_W    (PHASE_W)
    ) u_alloc (
        .clk         (CLK),
        .rst         (RESET),
        .i_cmd_valid (CMD_VALID),
        .i_cmd_on    (CMD_ON),
        .i_cmd_inc   (CMD_INC),
        .o_active    (active),
        .o_inc       (inc),
        .o_load      (load)
    );

    always_comb begin
        sample_v = '0;
        if (active[v_q]) begin
            case (wsel_q)
                WAVE_SAW:    sample_v = {~phase_q[v_q][PHASE_W-1],
                                         phase_q[v_q][PHASE_W-2 -: SAMPLE_W-1]};
                WAVE_SQUARE: sample_v = phase_q[v_q][PHASE_W-1] ? -SQ_MAX : SQ_MAX;
                default:     sample_v = $signed(ROM_DATA);
            endcase
        end
    end

`ifdef POLY_SYNTH_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc_q >>> MIX_SHIFT;
        if (shifted > SAT_HI)      mix_out = SAT_HI[SAMPLE_W-1:0];
        else if (shifted < SAT_LO) mix_out = SAT_LO[SAMPLE_W-1:0];
        else                       mix_out = shifted[SAMPLE_W-1:0];
    end
`else
    assign mix_out = SAMPLE_W'(acc_q >>> MIX_SHIFT);
`endif

    always_comb begin
        state_d      = state_q;
        v_d          = v_q;
        wcnt_d       = wcnt_q;
        wsel_d       = wsel_q;
        acc_d        = acc_q;
        rom_addr_d   = rom_addr_q;
        audio_d      = audio_q;
        fifo_write_d = 1'b0;
        phase_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!FIFO_FULL) begin
                    wsel_d  = WAVE_SEL;
                    v_d     = '0;
                    acc_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rom_addr_d = {wsel_q[0], phase_q[v_q][PHASE_W-1 -: ADDR_W]};
                wcnt_d     = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == WCNT_W'(ROM_LAT - 1)) state_d = ST_ACC;
                else                                wcnt_d  = wcnt_q + 1'b1;
            end
            ST_ACC: begin
                acc_d = acc_q + {{(ACC_W-SAMPLE_W){sample_v[SAMPLE_W-1]}}, sample_v};
                if (v_q == VIDX_W'(NUM_VOICES - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    v_d     = v_q + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_OUT: begin
                if (!FIFO_FULL) begin
                    audio_d      = mix_out;
                    fifo_write_d = 1'b1;
                    phase_step   = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A load strobe from the allocator overrides the frame-end phase step
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (load[i])                        phase_d[i] = '0;
            else if (phase_step && active[i])   phase_d[i] = phase_q[i] + inc[i];
            else                                phase_d[i] = phase_q[i];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            v_q          <= '0;
            wcnt_q       <= '0;
            wsel_q       <= '0;
            acc_q        <= '0;
            rom_addr_q   <= '0;
            audio_q      <= '0;
            fifo_write_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            v_q          <= v_d;
            wcnt_q       <= wcnt_d;
            wsel_q       <= wsel_d;
            acc_q        <= acc_d;
            rom_addr_q   <= rom_addr_d;
            audio_q      <= audio_d;
            fifo_write_q <= fifo_write_d;
            phase_q      <= phase_d;
        end
    end

    assign ROM_ADDR   = rom_addr_q;
    assign FIFO_WRITE = fifo_write_q;
    assign AUDIO_OUT  = audio_q;
    assign ACTIVE     = active;

endmodule

`default_nettype wire

// File: tb/tb_poly_synth.sv
// ============================================================================
// Module : tb_poly_synth
// Brief  : Directed self-checking bench for poly_synth (default parameters plus
//          a MIX_SHIFT=0 instance); 2-cycle ROM model returns {3'b0, addr}.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_poly_synth;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_ON = 1'b0;
    logic [23:0] CMD_INC = '0;
    logic [1:0]  WAVE_SEL = 2'd0;
    logic        FIFO_FULL = 1'b0;
    logic [15:0] rom_data, rom_p1, rom_p2;
    logic [12:0] rom_addr, rom_addr_m0;
    logic        fifo_write, fifo_write_m0;
    logic [15:0] audio, audio_m0;
    logic [3:0]  active, active_m0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    poly_synth dut (
        .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_ON(CMD_ON),
        .CMD_INC(CMD_INC), .WAVE_SEL(WAVE_SEL), .ROM_ADDR(rom_addr),
        .ROM_DATA(rom_data), .FIFO_FULL(FIFO_FULL), .FIFO_WRITE(fifo_write),
        .AUDIO_OUT(audio), .ACTIVE(active)
    );

    poly_synth #(.MIX_SHIFT(0)) dut_m0 (
        .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_ON(CMD_ON),
        .CMD_INC(CMD_INC), .WAVE_SEL(WAVE_SEL), .ROM_ADDR(rom_addr_m0),
        .ROM_DATA(rom_data), .FIFO_FULL(FIFO_FULL), .FIFO_WRITE(fifo_write_m0),
        .AUDIO_OUT(audio_m0), .ACTIVE(active_m0)
    );

    always @(posedge CLK) begin
        rom_p1 <= {3'b000, rom_addr};
        rom_p2 <= rom_p1;
    end
    assign rom_data = rom_p2;

    task automatic do_reset();
        RESET = 1'b1;
        CMD_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic send_cmd(input logic on, input logic [23:0] inc);
        CMD_VALID = 1'b1;
        CMD_ON    = on;
        CMD_INC   = inc;
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_write(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!fifo_write && n < 100);
        if (!fifo_write) begin
            checks++; errors++;
            $display("FAIL wait_write timeout after %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        FIFO_FULL = 1'b0;
        WAVE_SEL = 2'd2;
        repeat (2) @(negedge CLK);
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL reset_active got %b exp 0000", active); end
        checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b exp 0", fifo_write); end
        checks++; if (audio !== 16'h0000) begin errors++; $display("FAIL reset_audio got %h exp 0000", audio); end
        checks++; if (rom_addr !== 13'h0000) begin errors++; $display("FAIL reset_romaddr got %h exp 0000", rom_addr); end
        RESET = 1'b0;
    endtask

    task automatic test_idle_frames();
        int n;
        wait_write(n);
        wait_write(n);
        checks++; if (n != 18) begin errors++; $display("FAIL idle_period got %0d exp 18", n); end
        checks++; if (audio !== 16'h0000) begin errors++; $display("FAIL idle_audio got %h exp 0000", audio); end
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL idle_active got %b exp 0000", active); end
        wait_write(n);
        checks++; if (n != 18) begin errors++; $display("FAIL idle_period2 got %0d exp 18", n); end
    endtask

    task automatic test_saw();
        int n;
        WAVE_SEL = 2'd2;
        do_reset();
        wait_write(n);
        send_cmd(1'b1, 24'h013491);
        checks++; if (active !== 4'b0001) begin errors++; $display("FAIL saw_active got %b exp 0001", active); end
        wait_write(n);
        checks++; if (n != 17) begin errors++; $display("FAIL saw_period got %0d exp 17", n); end
        checks++; if (audio !== 16'hE000) begin errors++; $display("FAIL saw_first got %h exp E000", audio); end
        wait_write(n);
        checks++; if (audio !== 16'hE04D) begin errors++; $display("FAIL saw_second got %h exp E04D", audio); end
        checks++; if (dut.phase_q[0] !== 24'h026922) begin errors++; $display("FAIL saw_phase got %h exp 026922", dut.phase_q[0]); end
    endtask

    task automatic test_rom();
        int n;
        WAVE_SEL = 2'd1;
        do_reset();
        wait_write(n);
        send_cmd(1'b1, 24'h013491);
        wait_write(n);
        checks++; if (audio !== 16'h0400) begin errors++; $display("FAIL rom_bank1_a got %h exp 0400", audio); end
        wait_write(n);
        checks++; if (audio !== 16'h0404) begin errors++; $display("FAIL rom_bank1_b got %h exp 0404", audio); end
        WAVE_SEL = 2'd0;
        wait_write(n);
        checks++; if (audio !== 16'h0009) begin errors++; $display("FAIL rom_bank0 got %h exp 0009", audio); end
    endtask

    task automatic test_alloc();
        int n;
        WAVE_SEL = 2'd3;
        do_reset();
        wait_write(n);
        send_cmd(1'b1, 24'h013491);
        send_cmd(1'b1, 24'h016EF3);
        send_cmd(1'b1, 24'h019BE3);
        send_cmd(1'b1, 24'h01B461);
        send_cmd(1'b1, 24'h01E9D2);
        checks++; if (active !== 4'b1111) begin errors++; $display("FAIL alloc_active got %b exp 1111", active); end
        checks++; if (dut.u_alloc.inc_q[0] !== 24'h01E9D2) begin errors++; $display("FAIL steal_inc got %h exp 01E9D2", dut.u_alloc.inc_q[0]); end
        checks++; if (dut.u_alloc.ptr_q !== 2'd1) begin errors++; $display("FAIL steal_ptr got %0d exp 1", dut.u_alloc.ptr_q); end
        wait_write(n);
        wait_write(n);
        send_cmd(1'b1, 24'h016EF3);
        checks++; if (dut.phase_q[1] !== 24'h000000) begin errors++; $display("FAIL retrig_phase got %h exp 000000", dut.phase_q[1]); end
        checks++; if (dut.phase_q[2] !== 24'h0337C6) begin errors++; $display("FAIL other_phase got %h exp 0337C6", dut.phase_q[2]); end
        checks++; if (dut.phase_q[0] !== 24'h03D3A4) begin errors++; $display("FAIL stolen_phase got %h exp 03D3A4", dut.phase_q[0]); end
        checks++; if (active !== 4'b1111) begin errors++; $display("FAIL retrig_active got %b exp 1111", active); end
        send_cmd(1'b0, 24'h016EF3);
        checks++; if (active !== 4'b1101) begin errors++; $display("FAIL off_active got %b exp 1101", active); end
        send_cmd(1'b0, 24'h044B9C);
        checks++; if (active !== 4'b1101) begin errors++; $display("FAIL off_absent got %b exp 1101", active); end
        send_cmd(1'b1, 24'h000000);
        checks++; if (active !== 4'b1101) begin errors++; $display("FAIL on_zero got %b exp 1101", active); end
        send_cmd(1'b1, 24'h044B9C);
        checks++; if (active !== 4'b1111) begin errors++; $display("FAIL refill_active got %b exp 1111", active); end
        checks++; if (dut.u_alloc.inc_q[1] !== 24'h044B9C) begin errors++; $display("FAIL refill_inc got %h exp 044B9C", dut.u_alloc.inc_q[1]); end
        checks++; if (dut.u_alloc.ptr_q !== 2'd1) begin errors++; $display("FAIL refill_ptr got %0d exp 1", dut.u_alloc.ptr_q); end
        send_cmd(1'b1, 24'h055555);
        checks++; if (dut.u_alloc.inc_q[1] !== 24'h055555) begin errors++; $display("FAIL steal2_inc got %h exp 055555", dut.u_alloc.inc_q[1]); end
        checks++; if (dut.u_alloc.ptr_q !== 2'd2) begin errors++; $display("FAIL steal2_ptr got %0d exp 2", dut.u_alloc.ptr_q); end
    endtask

    task automatic test_fifo_full();
        int writes;
        WAVE_SEL = 2'd3;
        FIFO_FULL = 1'b1;
        do_reset();
        send_cmd(1'b1, 24'h013491);
        writes = 0;
        repeat (40) begin @(negedge CLK); if (fifo_write) writes++; end
        checks++; if (writes != 0) begin errors++; $display("FAIL full_nowrite got %0d exp 0", writes); end
        checks++; if (dut.phase_q[0] !== 24'h000000) begin errors++; $display("FAIL full_frozen got %h exp 000000", dut.phase_q[0]); end
        FIFO_FULL = 1'b0;
        repeat (10) @(negedge CLK);
        FIFO_FULL = 1'b1;
        writes = 0;
        repeat (20) begin @(negedge CLK); if (fifo_write) writes++; end
        checks++; if (writes != 0) begin errors++; $display("FAIL hold_nowrite got %0d exp 0", writes); end
        checks++; if (dut.phase_q[0] !== 24'h000000) begin errors++; $display("FAIL hold_frozen got %h exp 000000", dut.phase_q[0]); end
        FIFO_FULL = 1'b0;
        @(negedge CLK);
        checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL release_write got %b exp 1", fifo_write); end
        checks++; if (audio !== 16'h1FFF) begin errors++; $display("FAIL release_audio got %h exp 1FFF", audio); end
        checks++; if (dut.phase_q[0] !== 24'h013491) begin errors++; $display("FAIL release_phase got %h exp 013491", dut.phase_q[0]); end
    endtask

    task automatic test_mix();
        int n;
        logic [15:0] exp_m0;
`ifdef POLY_SYNTH_SAT_EN
        exp_m0 = 16'h7FFF;
`else
        exp_m0 = 16'hFFFC;
`endif
        WAVE_SEL = 2'd3;
        FIFO_FULL = 1'b0;
        do_reset();
        wait_write(n);
        send_cmd(1'b1, 24'h000101);
        send_cmd(1'b1, 24'h000202);
        send_cmd(1'b1, 24'h000303);
        send_cmd(1'b1, 24'h000404);
        wait_write(n);
        checks++; if (audio !== 16'h7FFF) begin errors++; $display("FAIL mix_shift2 got %h exp 7FFF", audio); end
        checks++; if (audio_m0 !== exp_m0) begin errors++; $display("FAIL mix_shift0 got %h exp %h", audio_m0, exp_m0); end
        checks++; if (fifo_write_m0 !== 1'b1) begin errors++; $display("FAIL mix_m0_write got %b exp 1", fifo_write_m0); end
    endtask

    task automatic test_reset_mid();
        int n;
        int writes;
        wait_write(n);
        repeat (4) @(negedge CLK);
        checks++; if (audio !== 16'h7FFF) begin errors++; $display("FAIL premid_audio got %h exp 7FFF", audio); end
        #2 RESET = 1'b1;
        #1;
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL mid_active got %b exp 0000", active); end
        checks++; if (audio !== 16'h0000) begin errors++; $display("FAIL mid_audio got %h exp 0000", audio); end
        checks++; if (rom_addr !== 13'h0000) begin errors++; $display("FAIL mid_romaddr got %h exp 0000", rom_addr); end
        checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL mid_write got %b exp 0", fifo_write); end
        @(negedge CLK);
        RESET = 1'b0;
        writes = 0;
        repeat (15) begin @(negedge CLK); if (fifo_write) writes++; end
        checks++; if (writes != 0) begin errors++; $display("FAIL mid_nowrite got %0d exp 0", writes); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_frames();
        test_saw();
        test_rom();
        test_alloc();
        test_fifo_full();
        test_mix();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
